// File: rtl/alu_sig_checker.sv
// alu_sig_checker
//   Compacts a stream of ALU results into a Galois-form MISR signature.
//   After NUM_VECTORS results it compares the signature with a golden
//   value and reports pass/fail.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse that begins a run (honoured in IDLE/DONE)
//   z_valid    in   z carries a result to absorb this cycle
//   z          in   ALU result under test
//   golden     in   expected signature, sampled in COMPARE
//   busy       out  high while a run is collecting or comparing
//   done       out  high once the run has finished
//   pass       out  comparison result, meaningful while done=1
//   signature  out  current MISR contents
//   count      out  number of results absorbed in the current run
module alu_sig_checker #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_VECTORS = 9,
  parameter int               CNT_W       = 16,
  parameter logic [WIDTH-1:0] POLY        = 32'h04C11DB7,
  parameter logic [WIDTH-1:0] SEED        = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             z_valid,
  input  logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VECTORS - 1);

  // One MISR step: shift left, fold the outgoing bit through POLY, XOR data in.
  function automatic logic [WIDTH-1:0] misr_next(input logic [WIDTH-1:0] sig,
                                                 input logic [WIDTH-1:0] din);
    logic [WIDTH-1:0] fb;
    fb = sig[WIDTH-1] ? POLY : {WIDTH{1'b0}};
    return {sig[WIDTH-2:0], 1'b0} ^ fb ^ din;
  endfunction

  state_t           state_q;
  logic [WIDTH-1:0] sig_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic [WIDTH-1:0] sig_d;
  logic [CNT_W-1:0] cnt_d;

  assign sig_d = misr_next(sig_q, z);
  assign cnt_d = cnt_q + CNT_W'(1);

  // Run-control FSM; every output is a register written here.
  // The first DONE cycle only settles busy/done, so busy drops and done
  // rises two edges after the last absorb, together with a stable pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sig_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            sig_q   <= SEED;
            cnt_q   <= {CNT_W{1'b0}};
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_COLLECT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_COLLECT: begin
          busy_q <= 1'b1;
          if (z_valid) begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
            if (cnt_q == LAST_CNT) begin
              state_q <= S_COMPARE;
            end else begin
              state_q <= S_COLLECT;
            end
          end else begin
            state_q <= S_COLLECT;
          end
        end
        S_COMPARE: begin
          busy_q  <= 1'b1;
          pass_q  <= (sig_q == golden);
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (start) begin
            // Restart: the start cycle absorbs nothing even with z_valid=1.
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            sig_q   <= SEED;
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= S_COLLECT;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_alu_sig_checker.sv
// Directed bench for alu_sig_checker. Three instances cover the default
// configuration, SEED=0/NUM_VECTORS=2, and SEED=80000000/NUM_VECTORS=1.
module tb_alu_sig_checker;

  logic clk;
  logic rst_n;

  // Default instance (SEED=FFFFFFFF, 9 vectors)
  logic        d_start, d_zv, d_busy, d_done, d_pass;
  logic [31:0] d_z, d_golden, d_sig;
  logic [15:0] d_cnt;
  // SEED=0, 2 vectors
  logic        s_start, s_zv, s_busy, s_done, s_pass;
  logic [31:0] s_z, s_golden, s_sig;
  logic [15:0] s_cnt;
  // SEED=80000000, 1 vector
  logic        o_start, o_zv, o_busy, o_done, o_pass;
  logic [31:0] o_z, o_golden, o_sig;
  logic [15:0] o_cnt;

  int n_checks;
  int n_errors;

  logic [31:0] vec [9] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
                           32'h11111111, 32'h11111111, 32'h00000000, 32'h11111111,
                           32'hFFFFFFFF};

  alu_sig_checker u_def (
    .clk(clk), .rst_n(rst_n), .start(d_start), .z_valid(d_zv), .z(d_z),
    .golden(d_golden), .busy(d_busy), .done(d_done), .pass(d_pass),
    .signature(d_sig), .count(d_cnt)
  );

  alu_sig_checker #(.NUM_VECTORS(2), .SEED(32'h00000000)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .z_valid(s_zv), .z(s_z),
    .golden(s_golden), .busy(s_busy), .done(s_done), .pass(s_pass),
    .signature(s_sig), .count(s_cnt)
  );

  alu_sig_checker #(.NUM_VECTORS(1), .SEED(32'h80000000)) u_one (
    .clk(clk), .rst_n(rst_n), .start(o_start), .z_valid(o_zv), .z(o_z),
    .golden(o_golden), .busy(o_busy), .done(o_done), .pass(o_pass),
    .signature(o_sig), .count(o_cnt)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference MISR step for the default polynomial
  function automatic logic [31:0] misr_f(input logic [31:0] sig, input logic [31:0] din);
    logic [31:0] r;
    r = {sig[30:0], 1'b0} ^ din;
    if (sig[31]) r = r ^ 32'h04C11DB7;
    return r;
  endfunction

  logic [31:0] exp_sig;
  logic [31:0] gapfree_sig;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    d_start = 1'b0; d_zv = 1'b0; d_z = 32'h0; d_golden = 32'h0;
    s_start = 1'b0; s_zv = 1'b0; s_z = 32'h0; s_golden = 32'h0;
    o_start = 1'b0; o_zv = 1'b0; o_z = 32'h0; o_golden = 32'h0;

    tick(); tick();
    check("rst_sig",  {32'h0, d_sig}, 64'h0);
    check("rst_cnt",  {48'h0, d_cnt}, 64'h0);
    check("rst_busy", {63'h0, d_busy}, 64'h0);
    check("rst_done", {63'h0, d_done}, 64'h0);
    check("rst_pass", {63'h0, d_pass}, 64'h0);
    rst_n = 1'b1;
    tick();

    // Single zero vector from default SEED
    d_start = 1'b1; tick(); d_start = 1'b0;
    check("start_busy", {63'h0, d_busy}, 64'h1);
    check("start_seed", {32'h0, d_sig}, 64'hFFFFFFFF);
    check("start_cnt",  {48'h0, d_cnt}, 64'h0);
    d_zv = 1'b1; d_z = 32'h0; tick(); d_zv = 1'b0;
    check("one_z_sig", {32'h0, d_sig}, 64'hFB3EE249);
    check("one_z_cnt", {48'h0, d_cnt}, 64'h1);

    // Three more vectors, then an asynchronous reset mid-run
    for (int i = 1; i < 4; i++) begin
      d_zv = 1'b1; d_z = i; tick();
    end
    d_zv = 1'b0;
    check("mid_cnt", {48'h0, d_cnt}, 64'h4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sig",  {32'h0, d_sig}, 64'h0);
    check("arst_cnt",  {48'h0, d_cnt}, 64'h0);
    check("arst_busy", {63'h0, d_busy}, 64'h0);
    check("arst_done", {63'h0, d_done}, 64'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", {63'h0, d_busy}, 64'h0);

    // Gap-free 9-vector run
    exp_sig = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) exp_sig = misr_f(exp_sig, vec[i]);
    d_golden = exp_sig;
    d_start = 1'b1; tick(); d_start = 1'b0;
    check("clean_seed", {32'h0, d_sig}, 64'hFFFFFFFF);
    for (int i = 0; i < 9; i++) begin
      d_zv = 1'b1; d_z = vec[i]; tick();
    end
    d_zv = 1'b0;
    check("run_sig",    {32'h0, d_sig}, {32'h0, exp_sig});
    check("run_cnt",    {48'h0, d_cnt}, 64'd9);
    check("run_busyN",  {63'h0, d_busy}, 64'h1);
    check("run_doneN",  {63'h0, d_done}, 64'h0);
    tick();
    check("run_busyN1", {63'h0, d_busy}, 64'h1);
    check("run_doneN1", {63'h0, d_done}, 64'h0);
    tick();
    check("run_busyN2", {63'h0, d_busy}, 64'h0);
    check("run_doneN2", {63'h0, d_done}, 64'h1);
    check("run_pass",   {63'h0, d_pass}, 64'h1);
    gapfree_sig = d_sig;

    // Restart from DONE with z_valid asserted: z must be dropped
    d_start = 1'b1; d_zv = 1'b1; d_z = 32'hFFFFFFFF; tick();
    d_start = 1'b0; d_zv = 1'b0;
    check("rs_done", {63'h0, d_done}, 64'h0);
    check("rs_pass", {63'h0, d_pass}, 64'h0);
    check("rs_sig",  {32'h0, d_sig}, 64'hFFFFFFFF);
    check("rs_cnt",  {48'h0, d_cnt}, 64'h0);
    check("rs_busy", {63'h0, d_busy}, 64'h1);

    // Same vectors with 0-3 idle cycles between them and stray start pulses
    for (int i = 0; i < 9; i++) begin
      for (int g = 0; g < (i % 4); g++) begin
        d_start = (g == 0); d_zv = 1'b0; d_z = 32'hDEADBEEF; tick();
      end
      d_start = 1'b0;
      check("gap_cnt", {48'h0, d_cnt}, i);
      d_zv = 1'b1; d_z = vec[i]; tick();
    end
    d_zv = 1'b0;
    for (int k = 0; k < 10 && !d_done; k++) tick();
    check("gap_done", {63'h0, d_done}, 64'h1);
    check("gap_sig",  {32'h0, d_sig}, {32'h0, gapfree_sig});
    check("gap_cnt9", {48'h0, d_cnt}, 64'd9);
    check("gap_pass", {63'h0, d_pass}, 64'h1);

    // SEED=0, two vectors, matching golden
    s_golden = 32'h00000002;
    s_start = 1'b1; tick(); s_start = 1'b0;
    s_zv = 1'b1; s_z = 32'h1; tick();
    s_z = 32'h0; tick(); s_zv = 1'b0;
    check("s0_sig", {32'h0, s_sig}, 64'h2);
    tick(); tick();
    check("s0_done", {63'h0, s_done}, 64'h1);
    check("s0_pass", {63'h0, s_pass}, 64'h1);
    // Mismatching golden
    s_golden = 32'h00000003;
    s_start = 1'b1; tick(); s_start = 1'b0;
    s_zv = 1'b1; s_z = 32'h1; tick();
    s_z = 32'h0; tick(); s_zv = 1'b0;
    tick(); tick();
    check("s0b_done", {63'h0, s_done}, 64'h1);
    check("s0b_pass", {63'h0, s_pass}, 64'h0);

    // SEED=80000000, one vector: feedback only, latency check
    o_golden = 32'h04C11DB7;
    check("one_idle_busy", {63'h0, o_busy}, 64'h0);
    o_start = 1'b1; tick(); o_start = 1'b0;
    check("one_coll_busy", {63'h0, o_busy}, 64'h1);
    o_zv = 1'b1; o_z = 32'h0; tick(); o_zv = 1'b0;
    check("one_sig",   {32'h0, o_sig}, 64'h04C11DB7);
    check("one_doneN", {63'h0, o_done}, 64'h0);
    tick();
    check("one_busyN1", {63'h0, o_busy}, 64'h1);
    check("one_doneN1", {63'h0, o_done}, 64'h0);
    tick();
    check("one_busyN2", {63'h0, o_busy}, 64'h0);
    check("one_doneN2", {63'h0, o_done}, 64'h1);
    check("one_pass",   {63'h0, o_pass}, 64'h1);
    o_zv = 1'b1; o_z = 32'h12345678; tick(); o_zv = 1'b0;
    check("one_hold_sig",  {32'h0, o_sig}, 64'h04C11DB7);
    check("one_hold_done", {63'h0, o_done}, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
